wb_mem_responder: RTL and testbench
===================================

Name: wb_mem_responder

Overview:
- Wishbone B4 slave memory model that sits directly on the core's ibus or dbus port inside the formal/sim harness. It replaces free random ack/data with a bounded-latency, data-consistent responder.
- Supports classic single cycles and linear incrementing bursts, with error responses for out-of-range addresses.
- A sticky protocol monitor flags master-side Wishbone violations so benches and properties can check them.

Parameters:
- DEPTH, 16, number of 32-bit words; power of two, 2..256.
- BASE, 32'h2000, byte base address; DEPTH*4 aligned.
- MAX_WAIT, 3, upper bound on wait states; 0..7.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- wb_adr  in  30  word address (byte address >> 2).
- wb_dat_w  in  32  write data.
- wb_sel  in  4  byte enables.
- wb_cyc  in  1  cycle valid.
- wb_stb  in  1  strobe.
- wb_we  in  1  write enable.
- wb_cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst.
- wb_bte  in  2  burst type; only 00 (linear) supported.
- wait_cfg  in  3  wait states per request; sampled at request accept; clamped to MAX_WAIT.
- wb_dat_r  out  32  read data; valid only in ack cycles.
- wb_ack  out  1  registered acknowledge.
- wb_err  out  1  registered error.
- proto_err  out  1  sticky master-violation flag.

Behaviour:
- Reset (resetn=0, async): state=IDLE; wb_ack=0, wb_err=0, wb_dat_r=0, proto_err=0; wait counter=0; burst pointer=0. Memory contents are not reset.
- In-range test: BASE/4 <= adr < BASE/4+DEPTH. Index = adr - BASE/4, DEPTH-bit-log2 wide.
- IDLE: on cyc&stb, latch adr/we/sel/dat_w/cti/bte, load wait count w=min(wait_cfg,MAX_WAIT), go to WAIT. ack/err stay 0 in the accept cycle.
- WAIT: decrement w each cycle. When w==0, go to RESP. Minimum latency from accept to ack is therefore 1 cycle; maximum is MAX_WAIT+1 cycles.
- RESP (1 cycle):
  - In range: ack=1.
    - Read: dat_r=mem[index].
    - Write: mem[index] updated per byte where sel[i]=1, at the same edge ack rises. dat_r=0.
  - Out of range: err=1, no write, dat_r=0.
  - Next state:
    - BURST if the latched cti=010, bte=00, request was in range and cyc still high.
    - Otherwise IDLE.
  - Unsupported bte with cti=010 is treated as classic (single ack).
- BURST:
  - Pointer = latched index+1, incremented after each acked beat.
  - Each cycle with cyc&stb: respond to the pointer with ack (or err if pointer >= DEPTH), zero wait states. A write uses the current dat_w/sel.
  - stb=0 with cyc=1: no ack, pointer held.
  - A beat acked with cti=111, or any err: go to IDLE.
- Back-to-back: ack/err are one-cycle pulses. In the cycle after RESP (classic), cyc&stb is a new request.
- cyc falling in WAIT or BURST: abort to IDLE next cycle. No ack, no write for the pending beat; w cleared.
- ack and err are never both 1. Neither is ever asserted while cyc=0 in the preceding cycle.
- proto_err is set, and stays set until reset, on any of:
  - stb=1 while cyc=0.
  - In WAIT, stb=1 with adr/we/sel differing from the latched value.
  - In WAIT, stb dropping while cyc=1.
- Reset asserted mid-operation: outputs clear immediately. A write in progress is lost unless its RESP edge has already occurred.

Test Plan:
- Classic write 0xDEADBEEF to byte 0x2004, sel=1111, wait_cfg=0, then read 0x2004 -> ack 1 cycle after each accept; read dat_r=0xDEADBEEF.
- wait_cfg=5, MAX_WAIT=3, read 0x2000 -> ack exactly 4 cycles after accept; no ack earlier.
- Partial write sel=0010, dat_w=0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
- Read 0x1FFC (out of range) -> err=1 for one cycle, ack=0, dat_r=0, memory unchanged.
- Burst read from index 13, cti 010,010,111, wait_cfg=1 -> beat 1 acked at cycle 2, beats 2–3 in consecutive cycles returning mem[14], mem[15]. A 4th beat starting at index 13 hits index 16 -> err, then IDLE.
- cyc dropped during WAIT with wait_cfg=3 -> no ack/err, state IDLE. A separate case with stb=1, cyc=0 -> proto_err=1, held until resetn pulses low.

Source files
------------

// File: rtl/wb_mem_responder.sv
// wb_mem_responder: Wishbone B4 slave memory model for the sim/formal harness.
// Responds with a bounded number of wait states, supports classic cycles and
// linear incrementing bursts, returns err outside its address window, and
// keeps a sticky flag for master-side protocol violations.
module wb_mem_responder #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] BASE     = 32'h2000,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [29:0] wb_adr,
    input  logic [31:0] wb_dat_w,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [2:0]  wb_cti,
    input  logic [1:0]  wb_bte,
    input  logic [2:0]  wait_cfg,
    output logic [31:0] wb_dat_r,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        proto_err
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [29:0] BASE_W  = BASE[31:2];
    localparam logic [29:0] LIMIT_W = BASE_W + 30'(DEPTH);
    localparam logic [2:0]  MAXW    = 3'(MAX_WAIT);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_BURST
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    wcnt_q, wcnt_d;
    // Burst pointer carries one extra bit so running off the end is visible.
    logic [AW:0]   ptr_q, ptr_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;
    logic          proto_q, proto_d;

    // Request fields captured at accept; only meaningful outside IDLE.
    logic [29:0]   adr_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   wdat_q;
    logic          burst_q;
    logic          inr_q;

    logic [31:0]   mem_q [DEPTH];

    logic          lat_en;
    logic          adr_in_range;
    logic          burst_mode;
    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_wdat;
    logic [3:0]    mem_wsel;

    assign adr_in_range = (wb_adr >= BASE_W) && (wb_adr < LIMIT_W);

    // Next-state, response and memory-write decode.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        ptr_d      = ptr_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_d      = '0;
        proto_d    = proto_q;
        lat_en     = 1'b0;
        burst_mode = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = adr_q[AW-1:0];
        mem_wdat   = wdat_q;
        mem_wsel   = sel_q;

        if (wb_stb && !wb_cyc) begin
            proto_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    lat_en  = 1'b1;
                    wcnt_d  = (wait_cfg > MAXW) ? MAXW : wait_cfg;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wb_cyc) begin
                    state_d = S_IDLE;
                    wcnt_d  = '0;
                end else begin
                    if (!wb_stb) begin
                        proto_d = 1'b1;
                    end else if ((wb_adr != adr_q) || (wb_we != we_q) || (wb_sel != sel_q)) begin
                        proto_d = 1'b1;
                    end
                    if (wcnt_q != 3'd0) begin
                        wcnt_d = wcnt_q - 3'd1;
                    end else begin
                        // The response edge: ack/err rise and a write lands together.
                        state_d = S_RESP;
                        ptr_d   = {1'b0, adr_q[AW-1:0]} + PTR_ONE;
                        if (inr_q) begin
                            ack_d = 1'b1;
                            if (we_q) begin
                                mem_we = 1'b1;
                            end else begin
                                dat_d = mem_q[adr_q[AW-1:0]];
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_RESP: begin
                if (wb_cyc && burst_q && inr_q) begin
                    burst_mode = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (wb_cyc) begin
                    burst_mode = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Zero-wait burst beats: each strobed cycle is answered at the pointer.
        if (burst_mode) begin
            state_d = S_BURST;
            if (wb_stb) begin
                if (ptr_q[AW]) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ack_d = 1'b1;
                    ptr_d = ptr_q + PTR_ONE;
                    if (wb_we) begin
                        mem_we   = 1'b1;
                        mem_idx  = ptr_q[AW-1:0];
                        mem_wdat = wb_dat_w;
                        mem_wsel = wb_sel;
                    end else begin
                        dat_d = mem_q[ptr_q[AW-1:0]];
                    end
                    if (wb_cti == 3'b111) begin
                        state_d = S_IDLE;
                    end
                end
            end
        end
    end

    // Control state and registered outputs, cleared asynchronously.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            ptr_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            proto_q <= proto_d;
        end
    end

    // Capture the accepted request for the wait/response phase.
    always_ff @(posedge clock) begin
        if (lat_en) begin
            adr_q   <= wb_adr;
            we_q    <= wb_we;
            sel_q   <= wb_sel;
            wdat_q  <= wb_dat_w;
            burst_q <= (wb_cti == 3'b010) && (wb_bte == 2'b00);
            inr_q   <= adr_in_range;
        end
    end

    // Byte-lane memory write; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wsel[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_r  = dat_q;
    assign wb_ack    = ack_q;
    assign wb_err    = err_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench for wb_mem_responder: classic, back-to-back, burst,
// abort, reset and protocol-monitor scenarios against a word-array model.
module tb_wb_mem_responder;

    localparam int          DEPTH    = 16;
    localparam int          MAX_WAIT = 3;
    localparam logic [29:0] BASE_W   = 30'h800;

    logic        clock    = 1'b0;
    logic        resetn   = 1'b0;
    logic [29:0] wb_adr   = '0;
    logic [31:0] wb_dat_w = '0;
    logic [3:0]  wb_sel   = '0;
    logic        wb_cyc   = 1'b0;
    logic        wb_stb   = 1'b0;
    logic        wb_we    = 1'b0;
    logic [2:0]  wb_cti   = '0;
    logic [1:0]  wb_bte   = '0;
    logic [2:0]  wait_cfg = '0;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];

    typedef struct packed {
        logic        we;
        logic [29:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  wcfg;
    } txn_t;

    always #5 clock = ~clock;

    wb_mem_responder #(.DEPTH(DEPTH), .BASE(32'h2000), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .resetn(resetn),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_cti(wb_cti), .wb_bte(wb_bte), .wait_cfg(wait_cfg),
        .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err), .proto_err(proto_err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic bit in_rng(input logic [29:0] a);
        return (a >= BASE_W) && (a < BASE_W + 30'(DEPTH));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Accept edge plus w wait edges plus the response edge.
    function automatic int exp_edges(input logic [2:0] w);
        return ((int'(w) > MAX_WAIT) ? MAX_WAIT : int'(w)) + 2;
    endfunction

    task automatic model_classic(input txn_t t, output logic eack, output logic eerr,
                                 output logic [31:0] edat, output int en);
        int idx;
        en   = exp_edges(t.wcfg);
        eack = in_rng(t.adr);
        eerr = !eack;
        edat = '0;
        if (eack) begin
            idx = int'(t.adr - BASE_W);
            if (t.we) ref_mem[idx] = merge(ref_mem[idx], t.dat, t.sel);
            else      edat = ref_mem[idx];
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int k);
        repeat (k) begin @(posedge clock); @(negedge clock); end
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        @(posedge clock); @(negedge clock);
        resetn = 1'b1;
    endtask

    // Drives one request from a negedge; n counts rising edges until ack/err.
    task automatic bus_classic(input txn_t t, input logic [2:0] cti, input logic [1:0] bte,
                               output int n, output logic ack, output logic err,
                               output logic [31:0] rdat);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = t.we; wb_adr = t.adr;
        wb_dat_w = t.dat; wb_sel = t.sel; wait_cfg = t.wcfg; wb_cti = cti; wb_bte = bte;
        n = 0; ack = 1'b0; err = 1'b0; rdat = '0;
        while (n < 20) begin
            @(posedge clock); @(negedge clock);
            n++;
            if (wb_ack || wb_err) begin
                ack = wb_ack; err = wb_err; rdat = wb_dat_r;
                break;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_cti = '0; wb_bte = '0;
    endtask

    // Linear burst from idx0 of len beats, checked beat by beat.
    task automatic run_burst(input int idx0, input int len, input logic we,
                             input logic [2:0] wcfg, input bit gaps);
        int          n, idx;
        logic [31:0] d, edat;
        logic [3:0]  s;
        d = $urandom; s = 4'($urandom_range(1, 15));
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = BASE_W + 30'(idx0);
        wb_dat_w = d; wb_sel = s; wait_cfg = wcfg; wb_bte = 2'b00;
        wb_cti = (len == 1) ? 3'b111 : 3'b010;
        n = 0;
        while (n < 20) begin
            @(posedge clock); @(negedge clock);
            n++;
            if (wb_ack || wb_err) break;
        end
        edat = we ? 32'h0 : ref_mem[idx0];
        if (we) ref_mem[idx0] = merge(ref_mem[idx0], d, s);
        checks++;
        if (n != exp_edges(wcfg) || wb_ack !== 1'b1 || wb_err !== 1'b0 || wb_dat_r !== edat) begin
            errors++;
            $display("FAIL burst_beat1 idx=%0d: got edges=%0d ack=%b err=%b dat=%h, want edges=%0d ack=1 err=0 dat=%h",
                     idx0, n, wb_ack, wb_err, wb_dat_r, exp_edges(wcfg), edat);
        end
        for (int k = 1; k < len; k++) begin
            idx = idx0 + k;
            if (gaps && $urandom_range(0, 2) == 0) begin
                wb_stb = 1'b0;
                @(posedge clock); @(negedge clock);
                checks++;
                if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_gap idx=%0d: got ack=%b err=%b, want ack=0 err=0", idx, wb_ack, wb_err);
                end
                wb_stb = 1'b1;
            end
            d = $urandom; s = 4'($urandom_range(0, 15));
            wb_dat_w = d; wb_sel = s; wb_adr = BASE_W + 30'(idx);
            wb_cti = (k == len - 1) ? 3'b111 : 3'b010;
            @(posedge clock); @(negedge clock);
            if (idx >= DEPTH) begin
                checks++;
                if (wb_ack !== 1'b0 || wb_err !== 1'b1 || wb_dat_r !== 32'h0) begin
                    errors++;
                    $display("FAIL burst_overrun idx=%0d: got ack=%b err=%b dat=%h, want ack=0 err=1 dat=0",
                             idx, wb_ack, wb_err, wb_dat_r);
                end
                break;
            end
            edat = we ? 32'h0 : ref_mem[idx];
            if (we) ref_mem[idx] = merge(ref_mem[idx], d, s);
            checks++;
            if (wb_ack !== 1'b1 || wb_err !== 1'b0 || wb_dat_r !== edat) begin
                errors++;
                $display("FAIL burst_beat idx=%0d: got ack=%b err=%b dat=%h, want ack=1 err=0 dat=%h",
                         idx, wb_ack, wb_err, wb_dat_r, edat);
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_cti = '0;
        @(posedge clock); @(negedge clock);
        checks++;
        if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
            errors++;
            $display("FAIL burst_tail: got ack=%b err=%b, want ack=0 err=0", wb_ack, wb_err);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({wb_ack, wb_err, proto_err, wb_dat_r} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b err=%b proto=%b dat=%h, want all 0",
                     wb_ack, wb_err, proto_err, wb_dat_r);
        end
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic test_classic();
        txn_t        q[$];
        txn_t        t;
        logic        eack, eerr, ack, err;
        logic [31:0] edat, rdat;
        int          en, n;
        for (int i = 0; i < DEPTH; i++) q.push_back('{1'b1, BASE_W + 30'(i), $urandom, 4'hF, 3'd0});
        q.push_back('{1'b1, 30'h801, 32'hDEADBEEF, 4'hF, 3'd0});
        q.push_back('{1'b0, 30'h801, 32'h0,        4'hF, 3'd0});
        q.push_back('{1'b0, 30'h800, 32'h0,        4'hF, 3'd5});
        q.push_back('{1'b1, 30'h803, 32'h11223344, 4'hF, 3'd2});
        q.push_back('{1'b1, 30'h803, 32'h0000AB00, 4'h2, 3'd1});
        q.push_back('{1'b0, 30'h803, 32'h0,        4'hF, 3'd7});
        q.push_back('{1'b0, 30'h7FF, 32'h0,        4'hF, 3'd0});
        q.push_back('{1'b1, 30'h810, 32'hCAFEF00D, 4'hF, 3'd0});
        q.push_back('{1'b0, 30'h80F, 32'h0,        4'hF, 3'd3});
        q.push_back('{1'b1, 30'h80E, 32'h55AA55AA, 4'h9, 3'd0});
        q.push_back('{1'b0, 30'h80E, 32'h0,        4'hF, 3'd1});
        foreach (q[i]) begin
            t = q[i];
            model_classic(t, eack, eerr, edat, en);
            bus_classic(t, 3'b000, 2'b00, n, ack, err, rdat);
            checks++;
            if ({ack, err, rdat} !== {eack, eerr, edat} || n != en) begin
                errors++;
                $display("FAIL classic[%0d] adr=%h: got ack=%b err=%b dat=%h edges=%0d, want ack=%b err=%b dat=%h edges=%0d",
                         i, t.adr, ack, err, rdat, n, eack, eerr, edat, en);
            end
            idle(1);
            checks++;
            if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
                errors++;
                $display("FAIL classic_pulse[%0d]: got ack=%b err=%b, want 0 0", i, wb_ack, wb_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t        t;
        logic        eack, eerr, ack, err;
        logic [31:0] edat, rdat;
        int          en, n;
        bit          b2b;
        b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0)
                t.adr = $urandom_range(0, 1) ? BASE_W - 30'($urandom_range(1, 4))
                                             : BASE_W + 30'(DEPTH) + 30'($urandom_range(0, 3));
            else
                t.adr = BASE_W + 30'($urandom_range(0, DEPTH - 1));
            t.we   = 1'($urandom_range(0, 1));
            t.dat  = $urandom;
            t.sel  = 4'($urandom_range(0, 15));
            t.wcfg = 3'($urandom_range(0, 7));
            model_classic(t, eack, eerr, edat, en);
            if (b2b) en = en + 1;
            bus_classic(t, 3'b000, 2'b00, n, ack, err, rdat);
            checks++;
            if ({ack, err, rdat} !== {eack, eerr, edat} || n != en) begin
                errors++;
                $display("FAIL random[%0d] adr=%h we=%b b2b=%b: got ack=%b err=%b dat=%h edges=%0d, want ack=%b err=%b dat=%h edges=%0d",
                         i, t.adr, t.we, b2b, ack, err, rdat, n, eack, eerr, edat, en);
            end
            b2b = ($urandom_range(0, 1) == 1);
            if (!b2b) idle(1);
        end
        if (b2b) idle(1);
    endtask

    task automatic test_burst();
        int n;
        run_burst(13, 3, 1'b0, 3'd1, 1'b0);
        idle(1);
        run_burst(13, 4, 1'b0, 3'd1, 1'b0);
        idle(1);
        // Unsupported bte: a single ack only, even if the master keeps strobing.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = BASE_W + 30'd2;
        wb_sel = 4'hF; wait_cfg = 3'd0; wb_cti = 3'b010; wb_bte = 2'b01;
        n = 0;
        while (n < 20) begin
            @(posedge clock); @(negedge clock);
            n++;
            if (wb_ack || wb_err) break;
        end
        checks++;
        if (n != 2 || wb_ack !== 1'b1 || wb_dat_r !== ref_mem[2]) begin
            errors++;
            $display("FAIL bte01_first: got edges=%0d ack=%b dat=%h, want edges=2 ack=1 dat=%h",
                     n, wb_ack, wb_dat_r, ref_mem[2]);
        end
        wb_adr = BASE_W + 30'd3; wb_cti = 3'b111;
        @(posedge clock); @(negedge clock);
        checks++;
        if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin
            errors++;
            $display("FAIL bte01_second: got ack=%b err=%b, want ack=0 err=0", wb_ack, wb_err);
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = '0; wb_bte = '0;
        idle(1);
        for (int i = 0; i < 12; i++) begin
            run_burst($urandom_range(0, DEPTH - 1), $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), 1'b1);
            idle(1);
        end
    endtask

    task automatic test_abort();
        txn_t        t;
        logic        eack, eerr, ack, err;
        logic [31:0] edat, rdat;
        int          en, n, seen;
        for (int pass = 0; pass < 2; pass++) begin
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = (pass == 1); wb_adr = BASE_W + 30'd6;
            wb_dat_w = ~ref_mem[6]; wb_sel = 4'hF; wait_cfg = 3'd3; wb_cti = '0;
            idle(2);
            wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clock); @(negedge clock);
                if (wb_ack || wb_err) seen++;
            end
            checks++;
            if (seen != 0) begin
                errors++;
                $display("FAIL abort_silent[%0d]: got %0d responses, want 0", pass, seen);
            end
        end
        t = '{1'b0, BASE_W + 30'd6, 32'h0, 4'hF, 3'd0};
        model_classic(t, eack, eerr, edat, en);
        bus_classic(t, 3'b000, 2'b00, n, ack, err, rdat);
        checks++;
        if ({ack, err, rdat} !== {eack, eerr, edat} || n != en) begin
            errors++;
            $display("FAIL abort_readback: got ack=%b err=%b dat=%h edges=%0d, want ack=%b err=%b dat=%h edges=%0d",
                     ack, err, rdat, n, eack, eerr, edat, en);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        txn_t        t;
        logic        eack, eerr, ack, err;
        logic [31:0] edat, rdat;
        int          en, n;
        t = '{1'b0, BASE_W + 30'd4, 32'h0, 4'hF, 3'd0};
        model_classic(t, eack, eerr, edat, en);
        bus_classic(t, 3'b000, 2'b00, n, ack, err, rdat);
        checks++;
        if ({ack, err, rdat} !== {eack, eerr, edat} || n != en) begin
            errors++;
            $display("FAIL pre_reset_read: got ack=%b dat=%h edges=%0d, want ack=%b dat=%h edges=%0d",
                     ack, rdat, n, eack, edat, en);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (wb_ack !== 1'b0 || wb_dat_r !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got ack=%b dat=%h, want ack=0 dat=0", wb_ack, wb_dat_r);
        end
        @(negedge clock); resetn = 1'b1;
        idle(1);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = BASE_W + 30'd7;
        wb_dat_w = ~ref_mem[7]; wb_sel = 4'hF; wait_cfg = 3'd3;
        idle(2);
        resetn = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clock); @(negedge clock);
        resetn = 1'b1;
        t = '{1'b0, BASE_W + 30'd7, 32'h0, 4'hF, 3'd0};
        model_classic(t, eack, eerr, edat, en);
        bus_classic(t, 3'b000, 2'b00, n, ack, err, rdat);
        checks++;
        if ({ack, err, rdat} !== {eack, eerr, edat} || n != en) begin
            errors++;
            $display("FAIL lost_write: got ack=%b dat=%h edges=%0d, want ack=%b dat=%h edges=%0d",
                     ack, rdat, n, eack, edat, en);
        end
        idle(1);
    endtask

    task automatic test_proto();
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_clean: got proto=%b, want 0", proto_err);
        end
        wb_stb = 1'b1; wb_cyc = 1'b0;
        @(posedge clock); @(negedge clock);
        wb_stb = 1'b0;
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_stb_no_cyc: got proto=%b, want 1", proto_err);
        end
        idle(3);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky: got proto=%b, want 1", proto_err);
        end
        pulse_reset();
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_cleared: got proto=%b, want 0", proto_err);
        end
        for (int mode = 0; mode < 2; mode++) begin
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = BASE_W + 30'd1;
            wb_sel = 4'hF; wait_cfg = 3'd3;
            idle(1);
            if (mode == 0) wb_adr = BASE_W + 30'd2;
            else           wb_stb = 1'b0;
            idle(1);
            checks++;
            if (proto_err !== 1'b1) begin
                errors++;
                $display("FAIL proto_wait[%0d]: got proto=%b, want 1", mode, proto_err);
            end
            wb_cyc = 1'b0; wb_stb = 1'b0;
            idle(1);
            pulse_reset();
        end
    endtask

    initial begin
        test_reset();
        test_classic();
        test_back_to_back();
        test_burst();
        test_abort();
        test_reset_mid();
        test_proto();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
